// File: rtl/location_to_key.sv
// Decodes a tracked y coordinate into one of NUM_KEYS key lanes, debounces the
// lane across frames and emits note-on / note-off events for the note scheduler.
module location_to_key #(
  parameter int BASE_Y        = 485,
  parameter int PITCH         = 25,
  parameter int NUM_KEYS      = 8,
  parameter int STABLE_FRAMES = 3,
  parameter int Y_WIDTH       = 10
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [Y_WIDTH-1:0] y_in,
  input  logic               present_in,
  input  logic               y_valid_in,
  output logic [2:0]         key_out,
  output logic               key_active_out,
  output logic               note_on_out,
  output logic               note_off_out,
  output logic [2:0]         off_key_out
);

  localparam int HALF  = (PITCH - 1) / 2;
  localparam int SW    = Y_WIDTH + 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_FRAMES);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic signed [SW-1:0] y_ext;
  logic [NUM_KEYS-1:0]  lane_hit;
  logic                 dec_hit;
  logic [2:0]           dec_lane;

  logic                 s1_valid;
  logic                 s1_hit;
  logic [2:0]           s1_lane;

  logic                 cand_hit_q, cand_hit_d;
  logic [2:0]           cand_lane_q, cand_lane_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cand_same;
  logic                 commit;

  state_t               state_q, state_d;
  logic [2:0]           key_q, key_d;
  logic [2:0]           off_key_q, off_key_d;
  logic                 note_on_q, note_on_d;
  logic                 note_off_q, note_off_d;

  assign y_ext = $signed({1'b0, y_in});

  // Lane windows are fixed at elaboration; each lane is one range compare.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_lane
    localparam int LO_INT = BASE_Y - PITCH * k - HALF;
    localparam int HI_INT = LO_INT + PITCH - 1;
    localparam logic signed [SW-1:0] LO = (LO_INT < 0) ? '0 : SW'(LO_INT);
    localparam logic signed [SW-1:0] HI = SW'(HI_INT);

    assign lane_hit[k] = present_in && (y_ext >= LO) && (y_ext <= HI);
  end

  // Windows are disjoint, so the encoder order only matters for odd parameters.
  always_comb begin
    dec_hit  = |lane_hit;
    dec_lane = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (lane_hit[k]) begin
        dec_lane = 3'(k);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_lane  <= '0;
    end else begin
      s1_valid <= y_valid_in;
      if (y_valid_in) begin
        s1_hit  <= dec_hit;
        s1_lane <= dec_lane;
      end
    end
  end

  // A NONE candidate always carries lane 0, so a plain compare covers both fields.
  assign cand_same = (s1_hit == cand_hit_q) && (s1_lane == cand_lane_q);

  always_comb begin
    cand_hit_d  = cand_hit_q;
    cand_lane_d = cand_lane_q;
    cnt_d       = cnt_q;
    commit      = 1'b0;
    state_d     = state_q;
    key_d       = key_q;
    off_key_d   = off_key_q;
    note_on_d   = 1'b0;
    note_off_d  = 1'b0;

    if (s1_valid) begin
      cand_hit_d  = s1_hit;
      cand_lane_d = s1_lane;
      if (cand_same) begin
        if (cnt_q != STABLE_MAX) begin
          cnt_d  = cnt_q + 4'd1;
          commit = ((cnt_q + 4'd1) == STABLE_MAX);
        end
      end else begin
        cnt_d  = 4'd1;
        commit = (STABLE_MAX == 4'd1);
      end
    end

    // Only a commit that differs from the held state produces an event.
    if (commit) begin
      if (s1_hit) begin
        if (state_q == IDLE) begin
          state_d   = ACTIVE;
          key_d     = s1_lane;
          note_on_d = 1'b1;
        end else if (key_q != s1_lane) begin
          off_key_d  = key_q;
          note_off_d = 1'b1;
          key_d      = s1_lane;
          note_on_d  = 1'b1;
        end
      end else if (state_q == ACTIVE) begin
        state_d    = IDLE;
        off_key_d  = key_q;
        note_off_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cand_hit_q  <= 1'b0;
      cand_lane_q <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      key_q       <= '0;
      off_key_q   <= '0;
      note_on_q   <= 1'b0;
      note_off_q  <= 1'b0;
    end else begin
      cand_hit_q  <= cand_hit_d;
      cand_lane_q <= cand_lane_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      key_q       <= key_d;
      off_key_q   <= off_key_d;
      note_on_q   <= note_on_d;
      note_off_q  <= note_off_d;
    end
  end

  assign key_out        = key_q;
  assign key_active_out = (state_q == ACTIVE);
  assign note_on_out    = note_on_q;
  assign note_off_out   = note_off_q;
  assign off_key_out    = off_key_q;

endmodule

// File: tb/tb_location_to_key.sv
// Bench for location_to_key: a table of frame sequences with hand-derived
// outcomes, corner-case sequences and randomized frames against a lane/history model.
module tb_location_to_key;

  localparam int BASE_Y        = 485;
  localparam int PITCH         = 25;
  localparam int NUM_KEYS      = 8;
  localparam int STABLE_FRAMES = 3;
  localparam int Y_WIDTH       = 10;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic [Y_WIDTH-1:0] y_in;
  logic               present_in;
  logic               y_valid_in;
  logic [2:0]         key_out;
  logic               key_active_out;
  logic               note_on_out;
  logic               note_off_out;
  logic [2:0]         off_key_out;

  location_to_key #(
    .BASE_Y(BASE_Y),
    .PITCH(PITCH),
    .NUM_KEYS(NUM_KEYS),
    .STABLE_FRAMES(STABLE_FRAMES),
    .Y_WIDTH(Y_WIDTH)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .y_in(y_in),
    .present_in(present_in),
    .y_valid_in(y_valid_in),
    .key_out(key_out),
    .key_active_out(key_active_out),
    .note_on_out(note_on_out),
    .note_off_out(note_off_out),
    .off_key_out(off_key_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int key;
    bit active;
    bit on;
    bit off;
    int off_key;
  } out_t;

  typedef struct {
    int y;
    bit p;
    int exp_on;
    int exp_off;
    int key;
    bit active;
    int off_key;
  } vec_t;

  out_t exp_cur;
  out_t exp_next;
  int   hist[$];
  int   errors = 0;
  int   checks = 0;
  int   on_seen;
  int   off_seen;
  int   both_seen;
  vec_t tbl[13];

  // Lane from the window arithmetic: the top of lane 0 is its centre plus the upper half-width.
  function automatic int lane_of(int y, bit p);
    int top;
    int d;
    if (!p) return -1;
    top = BASE_Y + (PITCH - 1) - (PITCH - 1) / 2;
    d = top - y;
    if (d < 0 || d >= PITCH * NUM_KEYS) return -1;
    return d / PITCH;
  endfunction

  // A commit happens when the trailing run of identical candidates reaches exactly STABLE_FRAMES.
  task automatic model_sample(int y, bit p);
    int  cand;
    int  committed;
    bit  stable;
    cand = lane_of(y, p);
    hist.push_back(cand);
    if (hist.size() > STABLE_FRAMES + 1) void'(hist.pop_front());
    stable = (hist.size() >= STABLE_FRAMES);
    for (int i = 0; i < STABLE_FRAMES; i++) begin
      if (stable && hist[hist.size() - 1 - i] != cand) stable = 1'b0;
    end
    if (stable && hist.size() == STABLE_FRAMES + 1 && hist[0] == cand) stable = 1'b0;
    committed = exp_next.active ? exp_next.key : -1;
    if (stable && cand != committed) begin
      if (cand >= 0) begin
        if (exp_next.active) begin
          exp_next.off     = 1'b1;
          exp_next.off_key = exp_next.key;
        end
        exp_next.on     = 1'b1;
        exp_next.key    = cand;
        exp_next.active = 1'b1;
      end else begin
        exp_next.off     = 1'b1;
        exp_next.off_key = exp_next.key;
        exp_next.active  = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_cur  = '{key: 0, active: 1'b0, on: 1'b0, off: 1'b0, off_key: 0};
    exp_next = exp_cur;
  endtask

  task automatic checkOutput(string name, out_t e);
    checks++;
    if (key_out != 3'(e.key) || key_active_out != e.active || note_on_out != e.on ||
        note_off_out != e.off || off_key_out != 3'(e.off_key)) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got key=%0d act=%0b on=%0b off=%0b offkey=%0d, expected key=%0d act=%0b on=%0b off=%0b offkey=%0d",
               name, $time, key_out, key_active_out, note_on_out, note_off_out, off_key_out,
               e.key, e.active, e.on, e.off, e.off_key);
    end
  endtask

  task automatic check_val(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // One clock cycle: drive inputs, step the model one edge, compare every output.
  task automatic applyStimulus(bit v, int y, bit p);
    y_valid_in = v;
    y_in       = Y_WIDTH'(y);
    present_in = p;
    @(posedge clk_in);
    #1;
    exp_cur      = exp_next;
    exp_next.on  = 1'b0;
    exp_next.off = 1'b0;
    if (v) model_sample(y, p);
    checkOutput("cycle_out", exp_cur);
    if (note_on_out) on_seen++;
    if (note_off_out) off_seen++;
    if (note_on_out && note_off_out) both_seen++;
  endtask

  task automatic frame(int y, bit p, int gap);
    applyStimulus(1'b1, y, p);
    for (int i = 0; i < gap; i++) applyStimulus(1'b0, 0, 1'b0);
  endtask

  task automatic clear_seen();
    on_seen   = 0;
    off_seen  = 0;
    both_seen = 0;
  endtask

  initial begin
    int base;
    int yr;

    tbl[0]  = '{485, 1'b1, 1, 0, 0, 1'b1, 0};
    tbl[1]  = '{0,   1'b0, 0, 1, 0, 1'b0, 0};
    tbl[2]  = '{497, 1'b1, 1, 0, 0, 1'b1, 0};
    tbl[3]  = '{0,   1'b0, 0, 1, 0, 1'b0, 0};
    tbl[4]  = '{498, 1'b1, 0, 0, 0, 1'b0, 0};
    tbl[5]  = '{473, 1'b1, 1, 0, 0, 1'b1, 0};
    tbl[6]  = '{0,   1'b0, 0, 1, 0, 1'b0, 0};
    tbl[7]  = '{472, 1'b1, 1, 0, 1, 1'b1, 0};
    tbl[8]  = '{0,   1'b0, 0, 1, 1, 1'b0, 1};
    tbl[9]  = '{298, 1'b1, 1, 0, 7, 1'b1, 1};
    tbl[10] = '{0,   1'b0, 0, 1, 7, 1'b0, 7};
    tbl[11] = '{297, 1'b1, 0, 0, 7, 1'b0, 7};
    tbl[12] = '{485, 1'b0, 0, 0, 7, 1'b0, 7};

    rst_in     = 1'b0;
    y_in       = '0;
    present_in = 1'b0;
    y_valid_in = 1'b0;
    model_reset();
    #1;
    checkOutput("reset_state", exp_cur);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    $display("[TB] table vectors");
    for (int t = 0; t < 13; t++) begin
      clear_seen();
      for (int f = 0; f < 3; f++) frame(tbl[t].y, tbl[t].p, 5);
      check_val($sformatf("tbl%0d_on", t), on_seen, tbl[t].exp_on);
      check_val($sformatf("tbl%0d_off", t), off_seen, tbl[t].exp_off);
      check_val($sformatf("tbl%0d_key", t), int'(key_out), tbl[t].key);
      check_val($sformatf("tbl%0d_act", t), int'(key_active_out), int'(tbl[t].active));
      check_val($sformatf("tbl%0d_offkey", t), int'(off_key_out), tbl[t].off_key);
    end

    $display("[TB] jitter");
    clear_seen();
    frame(485, 1'b1, 5);
    frame(460, 1'b1, 5);
    frame(485, 1'b1, 5);
    frame(485, 1'b1, 5);
    check_val("jitter_early_on", on_seen, 0);
    frame(485, 1'b1, 5);
    check_val("jitter_on", on_seen, 1);
    check_val("jitter_off", off_seen, 0);
    check_val("jitter_key", int'(key_out), 0);

    $display("[TB] key change back-to-back");
    clear_seen();
    frame(410, 1'b1, 0);
    frame(410, 1'b1, 0);
    frame(410, 1'b1, 4);
    check_val("change_both", both_seen, 1);
    check_val("change_on", on_seen, 1);
    check_val("change_off", off_seen, 1);
    check_val("change_offkey", int'(off_key_out), 0);
    check_val("change_key", int'(key_out), 3);

    $display("[TB] release");
    clear_seen();
    for (int f = 0; f < 3; f++) frame(410, 1'b0, 2);
    check_val("release_off", off_seen, 1);
    check_val("release_on", on_seen, 0);
    check_val("release_offkey", int'(off_key_out), 3);
    check_val("release_act", int'(key_active_out), 0);
    clear_seen();
    frame(410, 1'b0, 4);
    check_val("release_4th_pulses", on_seen + off_seen, 0);

    $display("[TB] async reset mid-note");
    for (int f = 0; f < 3; f++) frame(485, 1'b1, 3);
    check_val("pre_reset_act", int'(key_active_out), 1);
    #3 rst_in = 1'b0;
    model_reset();
    #1;
    checkOutput("async_reset_out", exp_cur);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    clear_seen();
    frame(485, 1'b1, 5);
    frame(485, 1'b1, 5);
    check_val("post_reset_early", on_seen + off_seen, 0);
    frame(485, 1'b1, 5);
    check_val("post_reset_on", on_seen, 1);
    check_val("post_reset_off", off_seen, 0);
    check_val("post_reset_key", int'(key_out), 0);

    $display("[TB] random frames");
    base = 485;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) base = int'($urandom_range(520, 280));
      yr = base + int'($urandom_range(8)) - 4;
      applyStimulus(1'($urandom_range(1)), yr, ($urandom_range(9) != 0));
    end
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/location_to_key.md
Name: location_to_key

Overview:
- Inverse of the key-to-screen-location mapping. Takes a tracked vertical pixel coordinate (one sample per video frame from the object tracker) and decodes which of the 8 key lanes it falls in.
- Debounces the lane over consecutive frames and emits note-on/note-off events to the synth/note scheduler.
- Sits between the camera tracking pipeline and audio note generation.

Parameters:
- BASE_Y, 485: lane-0 centre y coordinate.
- PITCH, 25: centre spacing; lane k centre = BASE_Y - PITCH*k.
- NUM_KEYS, 8: number of lanes.
- STABLE_FRAMES, 3: consecutive identical samples required to commit a change (legal range 1..15).
- Y_WIDTH, 10: coordinate width.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- y_in  input  Y_WIDTH  tracked y coordinate, unsigned
- present_in  input  1  tracker sees an object this frame
- y_valid_in  input  1  single-cycle strobe: y_in/present_in valid
- key_out  output  3  currently committed key index
- key_active_out  output  1  a key is currently held
- note_on_out  output  1  one-cycle pulse: key_out newly pressed
- note_off_out  output  1  one-cycle pulse: off_key_out released
- off_key_out  output  3  key index being released, held until next release

Behaviour:
- Lane window: HALF = (PITCH-1)/2 = 12. Lane k covers y in [centre_k - HALF, centre_k + PITCH-1-HALF], inclusive, so windows are contiguous.
  - Defaults: lane 0 = 473..497, lane 1 = 448..472, ..., lane 7 = 298..322.
- Candidate lane is NONE if:
  - y is outside all windows, or
  - present_in = 0.
- Decode uses NUM_KEYS parallel comparisons; no divider. Bounds are computed at elaboration with Y_WIDTH+1-bit signed math. A negative lower bound clamps to 0.
- Stage 1 (register): on y_valid_in, capture cand_lane and a hit flag; assert s1_valid the next cycle. Cycles without y_valid_in change nothing.
- Stage 2 (debounce), per s1_valid:
  - If cand equals the stored candidate, increment stable_cnt, saturating at STABLE_FRAMES.
  - Otherwise store cand and set stable_cnt = 1.
  - Commit happens on the sample where stable_cnt becomes exactly STABLE_FRAMES and cand differs from the committed state. A sample that only keeps stable_cnt saturated does not commit.
- Committed-state FSM, states IDLE and ACTIVE(k):
  - IDLE -> ACTIVE(k): note_on_out=1, key_out=k, key_active_out=1.
  - ACTIVE(j) -> ACTIVE(k), k!=j: note_off_out=1 and note_on_out=1 in the same cycle; off_key_out=j, key_out=k.
  - ACTIVE(j) -> IDLE (cand NONE committed): note_off_out=1, off_key_out=j, key_active_out=0. key_out holds j.
  - A commit equal to the current state produces no event.
- Latency: a sample strobed in cycle n produces committed-state and pulse changes in cycle n+2. Pulses are exactly one cycle wide.
- Back-to-back y_valid_in on consecutive cycles must be supported at full rate.
- Reset (any time, including mid-note):
  - Clears stage-1 state, the stored candidate (NONE), stable_cnt=0 and the FSM to IDLE.
  - All outputs go to 0: key_out=0, off_key_out=0, key_active_out=0, note_on_out=0, note_off_out=0.
  - No note_off is generated for a note interrupted by reset.
- STABLE_FRAMES=1: every differing sample commits immediately.

Test Plan:
- Reset, then y=485/present=1 strobed 3 times (gaps of 5 idle cycles) -> note_on_out pulses once, 2 cycles after the 3rd strobe; key_out=0, key_active_out=1; no pulse on strobes 1-2.
- Boundary sweep, 3 frames each with a release between:
  - 497 -> key 0; 498 -> no event; 473 -> key 0; 472 -> key 1.
  - 298 -> key 7; 297 -> no event.
  - present=0 with y=485 -> no event.
- Jitter: y = 485, 460, 485, 485, 485 -> single note_on key 0 after the 5th sample; no other pulses.
- Key change: hold key 0 active, then y=410 for 3 back-to-back strobes -> same-cycle note_on_out=1/note_off_out=1, off_key_out=0, key_out=3.
- Release: key 3 active, present_in=0 for 3 frames -> note_off_out pulse, off_key_out=3, key_active_out=0; a 4th NONE frame -> no pulse.
- Asynchronous reset asserted mid-ACTIVE, between clock edges -> outputs zero immediately with no pulse. After release, the first 2 strobes of y=485 produce no event; the 3rd yields note_on key 0.
